// File: rtl/k2_pkg.sv
// Shared types and sizing for the K2 fetch stage.
// Build option: define K2_FETCH_BOUNDS_EN to reject out-of-range jumps (see k2_fetch_unit).
package k2_pkg;

    localparam int K2_ADDR_W   = 4;
    localparam int K2_DATA_W   = 8;
    localparam int K2_PROG_LEN = 9;

    typedef logic [K2_ADDR_W-1:0] pc_t;
    typedef logic [K2_DATA_W-1:0] instr_t;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

endpackage

// File: rtl/k2_pc_next.sv
// Sequential PC successor with wrap after the last populated ROM word,
// plus the out-of-range check for jump targets.
module k2_pc_next
    import k2_pkg::*;
#(
    parameter int ADDR_W   = K2_ADDR_W,
    parameter int PROG_LEN = K2_PROG_LEN
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [ADDR_W-1:0] o_nxt,
    output logic              o_jump_oob
);

    // Compare in 32 bits so PROG_LEN == 2**ADDR_W cannot alias to zero.
    logic [31:0] w_pc_ext;
    logic [31:0] w_jump_ext;

    assign w_pc_ext   = {{(32-ADDR_W){1'b0}}, i_pc};
    assign w_jump_ext = {{(32-ADDR_W){1'b0}}, i_jump_addr};

    assign o_nxt      = (w_pc_ext >= 32'(PROG_LEN - 1)) ? '0 : i_pc + ADDR_W'(1);
    assign o_jump_oob = (w_jump_ext >= 32'(PROG_LEN));

endmodule

// File: rtl/k2_fetch_unit.sv
// K2 instruction fetch: PC, ROM addressing, registered instruction with valid/ready.
// Build option: K2_FETCH_BOUNDS_EN enables out-of-range jump rejection and fetch_err.
module k2_fetch_unit
    import k2_pkg::*;
#(
    parameter int ADDR_W   = K2_ADDR_W,
    parameter int DATA_W   = K2_DATA_W,
    parameter int PROG_LEN = K2_PROG_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [DATA_W-1:0] r_instr, w_instr_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_halt_pend, w_halt_pend_nxt;
    logic              w_ld, w_oob, w_start_ok;

    k2_pc_next #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) u_pc_next (
        .i_pc        (r_pc),
        .i_jump_addr (jump_addr),
        .o_nxt       (w_pc_inc),
        .o_jump_oob  (w_oob)
    );

    assign w_ld = !r_valid || instr_ready;

`ifdef K2_FETCH_BOUNDS_EN
    logic r_err, w_err_nxt;
    assign w_start_ok = start && !r_err;
    assign fetch_err  = r_err;
`else
    logic w_unused_oob;
    assign w_unused_oob = w_oob;
    assign w_start_ok   = start;
    assign fetch_err    = 1'b0;
`endif

    // Jump beats halt beats load; a pending halt retires once the held word is taken.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_valid_nxt     = r_valid;
        w_halt_pend_nxt = r_halt_pend;
`ifdef K2_FETCH_BOUNDS_EN
        w_err_nxt       = r_err;
`endif
        if (jump_en) begin
`ifdef K2_FETCH_BOUNDS_EN
            if (w_oob) begin
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b1;
                w_state_nxt = HALT;
            end else begin
                w_pc_nxt    = jump_addr;
                w_valid_nxt = 1'b0;
            end
`else
            w_pc_nxt    = jump_addr;
            w_valid_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (w_start_ok) w_state_nxt = RUN;
                end
                RUN: begin
                    if (halt || r_halt_pend) begin
                        if (w_ld) begin
                            w_state_nxt     = HALT;
                            w_valid_nxt     = 1'b0;
                            w_halt_pend_nxt = 1'b0;
                        end else begin
                            w_halt_pend_nxt = 1'b1;
                        end
                    end else if (w_ld) begin
                        w_instr_nxt = rom_data;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_halt_pend <= 1'b0;
`ifdef K2_FETCH_BOUNDS_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_valid     <= w_valid_nxt;
            r_halt_pend <= w_halt_pend_nxt;
`ifdef K2_FETCH_BOUNDS_EN
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign rom_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;

endmodule
